// File: rtl/sar_adc_ctl.sv
// SAR ADC sequencer: scans the enabled channels through S/H reset, track, hold and a
// 10-step binary search on the comparator, emitting one done strobe per finished result.
module sar_adc_ctl #(
  parameter int N_CHNL  = 14,
  parameter int RST_CYC = 4,
  parameter int SMP_CYC = 8,
  parameter int SET_CYC = 2,
  localparam int CW     = (N_CHNL > 1) ? $clog2(N_CHNL) : 1
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic [N_CHNL-1:0] chnl_en,
  input  logic              comp_o,
  output logic [N_CHNL-1:0] dac_sel,
  output logic              sh_rst,
  output logic              sh_hold,
  output logic [9:0]        dac_code,
  output logic              busy,
  output logic              done,
  output logic [9:0]        result,
  output logic [CW-1:0]     res_chnl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_GAP,
    S_SMP,
    S_HLD,
    S_CNV,
    S_STO
  } state_t;

  // Phase counters count down to zero, so each load value is the phase length minus one.
  localparam logic [3:0] RST_LD = 4'(RST_CYC - 1);
  localparam logic [3:0] SMP_LD = 4'(SMP_CYC - 1);
  localparam logic [3:0] SET_LD = 4'(SET_CYC - 1);

  state_t              state;
  logic [N_CHNL-1:0]   shadow;
  logic [CW-1:0]       cur;
  logic [3:0]          cnt;
  logic [3:0]          bit_idx;

  logic [CW-1:0]       first_en;
  logic [CW-1:0]       first_sh;
  logic [CW-1:0]       next_idx;
  logic                next_vld;
  logic [N_CHNL-1:0]   cur_onehot;
  logic [9:0]          bit_mask;
  logic [9:0]          trial_keep;

  // Channel selection: the descending loop leaves the lowest qualifying index in place.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    first_en   = '0;
    first_sh   = '0;
    next_idx   = '0;
    next_vld   = 1'b0;
    cur_onehot = '0;
    for (int i = N_CHNL - 1; i >= 0; i--) begin
      if (chnl_en[i]) first_en = CW'(i);
      if (shadow[i])  first_sh = CW'(i);
      if (shadow[i] && (i > int'(cur))) begin
        next_idx = CW'(i);
        next_vld = 1'b1;
      end
      cur_onehot[i] = (int'(cur) == i);
    end
  end

  // The trial code is kept bits plus the bit under test, so the decision either keeps it or drops it.
  always_comb begin
    bit_mask   = 10'd1 << bit_idx;
    trial_keep = comp_o ? dac_code : (dac_code & ~bit_mask);
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state    <= S_IDLE;
      shadow   <= '0;
      cur      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      dac_sel  <= '0;
      sh_rst   <= 1'b0;
      sh_hold  <= 1'b1;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      res_chnl <= '0;
    end else begin
      // NOTE: non-blocking throughout; this default is overridden by a later assignment on the STO entry edge.
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        dac_sel  <= '0;
        sh_rst   <= 1'b0;
        sh_hold  <= 1'b1;
        dac_code <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (chnl_en != '0)) begin
              state    <= S_RST;
              shadow   <= chnl_en;
              cur      <= first_en;
              cnt      <= RST_LD;
              sh_rst   <= 1'b1;
              sh_hold  <= 1'b1;
              dac_sel  <= '0;
              dac_code <= '0;
              busy     <= 1'b1;
            end
          end

          S_RST: begin
            if (cnt == 4'd0) begin
              state  <= S_GAP;
              sh_rst <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          S_GAP: begin
            state   <= S_SMP;
            cnt     <= SMP_LD;
            dac_sel <= cur_onehot;
            sh_hold <= 1'b0;
          end

          S_SMP: begin
            if (cnt == 4'd0) begin
              state   <= S_HLD;
              sh_hold <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          // Hold went high on the previous edge; only now is the channel released.
          S_HLD: begin
            state    <= S_CNV;
            dac_sel  <= '0;
            bit_idx  <= 4'd9;
            cnt      <= SET_LD;
            dac_code <= 10'h200;
          end

          S_CNV: begin
            if (cnt == 4'd0) begin
              if (bit_idx == 4'd0) begin
                state    <= S_STO;
                dac_code <= trial_keep;
                result   <= trial_keep;
                res_chnl <= cur;
                done     <= 1'b1;
              end else begin
                bit_idx  <= bit_idx - 4'd1;
                dac_code <= trial_keep | (bit_mask >> 1);
                cnt      <= SET_LD;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          S_STO: begin
            if (next_vld || cont) begin
              state    <= S_RST;
              cur      <= next_vld ? next_idx : first_sh;
              cnt      <= RST_LD;
              sh_rst   <= 1'b1;
              dac_code <= '0;
            end else begin
              state    <= S_IDLE;
              dac_code <= '0;
              busy     <= 1'b0;
            end
          end

          default: begin
            state    <= S_IDLE;
            dac_sel  <= '0;
            sh_rst   <= 1'b0;
            sh_hold  <= 1'b1;
            dac_code <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_ctl.sv
// Self-checking bench for sar_adc_ctl: a behavioural S/H + comparator macro, a
// scan-schedule reference model, and randomized channel sets and input voltages.
module tb_sar_adc_ctl;
  localparam int N_CHNL  = 14;
  localparam int RST_CYC = 4;
  localparam int SMP_CYC = 8;
  localparam int SET_CYC = 2;
  localparam int CW      = 4;
  localparam int PERIOD  = RST_CYC + SMP_CYC + 10 * SET_CYC + 3;

  logic              clk = 1'b0;
  logic              rstz = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              abort = 1'b0;
  logic [N_CHNL-1:0] chnl_en = '0;
  logic              comp_o;
  logic [N_CHNL-1:0] dac_sel;
  logic              sh_rst;
  logic              sh_hold;
  logic [9:0]        dac_code;
  logic              busy;
  logic              done;
  logic [9:0]        result;
  logic [CW-1:0]     res_chnl;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vin_mv[N_CHNL];
  int held_mv = 0;
  int viol = 0;
  int model_result = 0;
  logic [N_CHNL-1:0] prev_sel = '0;
  logic              prev_hold = 1'b1;

  typedef struct {
    int cyc;
    int chnl;
    int code;
  } done_t;
  done_t got_q[$];

  sar_adc_ctl #(
    .N_CHNL (N_CHNL),
    .RST_CYC(RST_CYC),
    .SMP_CYC(SMP_CYC),
    .SET_CYC(SET_CYC)
  ) dut (
    .clk     (clk),
    .rstz    (rstz),
    .start   (start),
    .cont    (cont),
    .abort   (abort),
    .chnl_en (chnl_en),
    .comp_o  (comp_o),
    .dac_sel (dac_sel),
    .sh_rst  (sh_rst),
    .sh_hold (sh_hold),
    .dac_code(dac_code),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .res_chnl(res_chnl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sel_idx(input logic [N_CHNL-1:0] v);
    for (int i = 0; i < N_CHNL; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [N_CHNL-1:0] onehot(input int ch);
    logic [N_CHNL-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // Ideal converter: largest code whose 2 mV-per-LSB level is still below the input.
  function automatic int sar_ref(input int mv);
    if (mv <= 0) return 0;
    if ((mv - 1) / 2 > 1023) return 1023;
    return (mv - 1) / 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Macro model: the S/H tracks the selected channel while sh_hold is low.
  always @(negedge clk)
    if (!sh_hold && $onehot(dac_sel)) held_mv = vin_mv[sel_idx(dac_sel)];
  assign comp_o = (held_mv > 2 * int'(dac_code));

  // Done collector and analog-safety monitor.
  always @(negedge clk) begin
    done_t d;
    if (done === 1'b1) begin
      d.cyc  = cyc;
      d.chnl = int'(res_chnl);
      d.code = int'(result);
      got_q.push_back(d);
    end
    if (sh_rst && (dac_sel != '0)) viol++;
    if (!$onehot0(dac_sel)) viol++;
    if ((prev_sel != '0) && (dac_sel == '0) && !(sh_hold && prev_hold)) viol++;
    prev_sel  = dac_sel;
    prev_hold = sh_hold;
  end

  task automatic run_scan(input logic [N_CHNL-1:0] en, input int passes, input int abort_at,
                          input bit poke);
    done_t exp_q[$];
    done_t e;
    int chs[$];
    int k, n, last_cyc, first_res, b, tv;
    for (int i = 0; i < N_CHNL; i++) if (en[i]) chs.push_back(i);
    n = (abort_at > 0) ? 0 : chs.size() * passes;
    @(negedge clk);
    got_q.delete();
    chnl_en = en;
    cont    = (passes > 1);
    start   = 1'b1;
    k       = cyc;
    for (int j = 0; j < n; j++) begin
      e.cyc  = k + PERIOD * (j + 1);
      e.chnl = chs[j % chs.size()];
      e.code = sar_ref(vin_mv[e.chnl]);
      exp_q.push_back(e);
    end
    first_res = sar_ref(vin_mv[chs[0]]);
    last_cyc  = (abort_at > 0) ? k + abort_at + 3 : k + PERIOD * n + 1;
    while (cyc < last_cyc) begin
      @(negedge clk);
      start = poke && (cyc == k + 10);
      if (cyc == k + 3) chnl_en = N_CHNL'($urandom);
      if (abort_at > 0) abort = (cyc == k + abort_at);
      if ((passes > 1) && (cyc == k + PERIOD * (n - 1) + 1)) cont = 1'b0;
      if (cyc == k + 1) begin
        check("busy_rise", busy, 1);
        check("rst_phase", sh_rst, 1);
        check("rst_sel", dac_sel, 0);
      end
      if (cyc == k + 5) begin
        check("gap_rst", sh_rst, 0);
        check("gap_sel", dac_sel, 0);
      end
      if (cyc == k + 6) begin
        check("smp_sel", dac_sel, onehot(chs[0]));
        check("smp_hold", sh_hold, 0);
      end
      if ((cyc >= k + 15) && (cyc <= k + 34) && (((cyc - k - 15) % 2) == 0) &&
          ((abort_at == 0) || (cyc <= k + abort_at))) begin
        b  = 9 - (cyc - k - 15) / 2;
        tv = (first_res & ~((1 << (b + 1)) - 1)) | (1 << b);
        check("trial_code", dac_code, tv);
      end
      if ((abort_at > 0) && (cyc == k + abort_at + 1)) begin
        check("abort_busy", busy, 0);
        check("abort_sel", dac_sel, 0);
        check("abort_rst", sh_rst, 0);
        check("abort_hold", sh_hold, 1);
        check("abort_code", dac_code, 0);
        check("abort_result", result, model_result);
      end
      if ((abort_at == 0) && (cyc == k + PERIOD * n)) check("busy_at_sto", busy, 1);
      if ((abort_at == 0) && (cyc == k + PERIOD * n + 1)) begin
        check("busy_fall", busy, 0);
        check("idle_hold", sh_hold, 1);
      end
    end
    check("done_count", got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      check("done_cycle", got_q[j].cyc - k, exp_q[j].cyc - k);
      check("res_chnl", got_q[j].chnl, exp_q[j].chnl);
      check("result", got_q[j].code, exp_q[j].code);
    end
    if (n > 0) model_result = exp_q[n - 1].code;
    check("nonoverlap", viol, 0);
    viol = 0;
  endtask

  initial begin
    logic [N_CHNL-1:0] en;
    for (int i = 0; i < N_CHNL; i++) vin_mv[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_dac_sel", dac_sel, 0);
    check("rst_sh_hold", sh_hold, 1);
    rstz = 1'b1;
    @(negedge clk);
    check("rst_sh_rst", sh_rst, 0);
    check("rst_dac_code", dac_code, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_res_chnl", res_chnl, 0);

    // Single channel, then both ends of the input range.
    vin_mv[2] = 1351;
    run_scan(14'h0004, 1, 0, 1'b0);
    vin_mv[5] = 0;
    run_scan(14'h0020, 1, 0, 1'b0);
    vin_mv[5] = 5000;
    run_scan(14'h0020, 1, 0, 1'b0);

    // Multi-channel scan, start pulsed while busy, then continuous wrap.
    vin_mv[0] = 777; vin_mv[7] = 3;  vin_mv[13] = 2047;
    run_scan(14'h2081, 1, 0, 1'b1);
    run_scan(14'h2081, 2, 0, 1'b0);

    // Abort mid-conversion, then a normal conversion afterwards.
    vin_mv[9] = 4321;
    run_scan(14'h0200, 1, 20, 1'b0);
    run_scan(14'h0200, 1, 0, 1'b0);

    // start with no channels enabled is ignored.
    @(negedge clk);
    got_q.delete();
    chnl_en = '0;
    start   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("zero_en_busy", busy, 0);
    end
    start = 1'b0;
    check("zero_en_rst", sh_rst, 0);
    check("zero_en_done", got_q.size(), 0);

    for (int t = 0; t < 8; t++) begin
      en = N_CHNL'($urandom);
      if (en == '0) en = onehot($urandom_range(0, N_CHNL - 1));
      for (int i = 0; i < N_CHNL; i++) vin_mv[i] = $urandom_range(0, 5000);
      if (t % 4 == 3) run_scan(en, 1, $urandom_range(15, 34), 1'b0);
      else            run_scan(en, $urandom_range(1, 2), 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
